// File: rtl/seg7_display_writer.sv
// Encodes a 16-bit hex value plus dot mask into up to four 7-segment register writes.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank zero nibbles above the top non-zero digit).
module seg7_display_writer #(
    parameter int unsigned WRITE_GAP      = 0,
    parameter bit          SKIP_UNCHANGED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [15:0] value,
    input  logic [3:0]  dots,
    output logic        ready,
    output logic        en_w,
    output logic [1:0]  waddr,
    output logic [7:0]  data,
    output logic [1:0]  dbg_state
);
    // Handshake: a request is taken on the rising edge where valid && ready; ready is high only
    // while idle, value/dots are captured on that edge only, and valid at any other time is ignored.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLOT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_CYCLES = 4'(WRITE_GAP);

    state_t      state;
    logic [15:0] val_q;
    logic [3:0]  dots_q;
    logic [1:0]  d;
    logic [3:0]  gap_cnt;
    logic [7:0]  shadow [4];
    logic [3:0]  shadow_vld;

    logic [3:0]  nib;
    logic        blank;
    logic [7:0]  slot_byte;
    logic        need_write;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0:    encode = 7'b1000000;
            4'h1:    encode = 7'b1111001;
            4'h2:    encode = 7'b0100100;
            4'h3:    encode = 7'b0110000;
            4'h4:    encode = 7'b0011001;
            4'h5:    encode = 7'b0010010;
            4'h6:    encode = 7'b0000010;
            4'h7:    encode = 7'b1111000;
            4'h8:    encode = 7'b0000000;
            4'h9:    encode = 7'b0010000;
            4'hA:    encode = 7'b0001000;
            4'hB:    encode = 7'b0000011;
            4'hC:    encode = 7'b1000110;
            4'hD:    encode = 7'b0100001;
            4'hE:    encode = 7'b0000110;
            default: encode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        nib   = val_q[{d, 2'b00} +: 4];
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Digit d is a leading zero when it and every higher nibble are zero; digit 0 always shows.
        blank = (d != 2'd0) && ((val_q >> {d, 2'b00}) == 16'h0000);
`else
        blank = 1'b0;
`endif
        slot_byte  = {dots_q[d], blank ? 7'h7F : encode(nib)};
        need_write = !SKIP_UNCHANGED || !shadow_vld[d] || (slot_byte != shadow[d]);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            en_w       <= 1'b0;
            waddr      <= 2'd0;
            data       <= 8'h00;
            val_q      <= 16'h0000;
            dots_q     <= 4'h0;
            d          <= 2'd0;
            gap_cnt    <= 4'd0;
            shadow_vld <= 4'h0;
            for (int i = 0; i < 4; i++) shadow[i] <= 8'h00;
        end else begin
            en_w <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid && ready) begin
                        val_q  <= value;
                        dots_q <= dots;
                        d      <= 2'd0;
                        ready  <= 1'b0;
                        state  <= S_SLOT;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_SLOT: begin
                    if (need_write) begin
                        en_w          <= 1'b1;
                        waddr         <= d;
                        data          <= slot_byte;
                        shadow[d]     <= slot_byte;
                        shadow_vld[d] <= 1'b1;
                    end
                    if (need_write && (GAP_CYCLES != 4'd0)) begin
                        gap_cnt <= GAP_CYCLES - 4'd1;
                        state   <= S_GAP;
                    end else if (d == 2'd3) begin
                        state <= S_IDLE;
                    end else begin
                        d <= d + 2'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (d == 2'd3) begin
                        state <= S_IDLE;
                    end else begin
                        d     <= d + 2'd1;
                        state <= S_SLOT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/seg7_display_writer.md
Name: seg7_display_writer

Overview:
- Write-side initiator for the 4-digit 7-segment controller's register-write port (en_w/waddr/data).
- Accepts a 16-bit hex value plus a 4-bit dot mask over a valid/ready handshake.
- Encodes each nibble into the active-low 7-segment pattern and issues up to four sequential single-cycle register writes.
- Sits between application logic (counters, debug values) and the display controller.

Parameters:
- WRITE_GAP, 0: idle cycles inserted after each issued write before the next digit slot (0..15).
- SKIP_UNCHANGED, 1: when 1, a digit whose {dot, segments} byte equals the last byte written to that address is not rewritten.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  request strobe; the transaction is accepted when valid && ready.
- value  input  16  hex value; nibble i (value[4i+3:4i]) goes to waddr i.
- dots  input  4  dot bit i goes to data[7] for waddr i.
- ready  output  1  high only in IDLE.
- en_w  output  1  write strobe to the controller, one cycle per write.
- waddr  output  2  digit address.
- data  output  8  {dot, seg[6:0]}; seg is active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Encoding, hex digits 0-F to seg[6:0]: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Reset (rst=0, asynchronous): state=IDLE, ready=0 while rst is asserted, then 1 from the first clk edge after release. en_w=0, waddr=0, data=0. All four shadow entries are marked invalid. Reset during a transaction abandons it immediately; no further writes are issued.
- States:
  - IDLE: ready=1. On valid, latch value and dots, set digit index d=0, go to SLOT.
  - SLOT: evaluate digit d, computing byte b.
    - Write case (SKIP_UNCHANGED=0, shadow[d] invalid, or b != shadow[d]): register en_w=1, waddr=d, data=b for exactly one cycle; set shadow[d]=b and mark it valid.
    - Skip case: the slot lasts one cycle with en_w=0.
    - Next state: GAP if a write was issued and WRITE_GAP>0. Otherwise, if d==3 go to IDLE, else increment d and stay in SLOT.
  - GAP: count WRITE_GAP cycles with en_w=0, then advance as above.
- Outputs are registered.
  - Accept edge at cycle T: the slot-0 write is visible during T+1.
  - With WRITE_GAP=0 and no skips, writes occupy T+1..T+4 and ready=1 again at T+5.
- Transaction length is slots(4) + WRITE_GAP × (number of writes). A fully skipped transaction still takes 4 cycles.
- waddr and data hold their last values when en_w=0; only the en_w qualification matters.
- valid while ready=0 is ignored; no queuing. value and dots are sampled only at acceptance. Changes during a transaction do not affect it.
- Back-to-back: valid held high continuously is re-accepted in the first ready cycle.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: every zero nibble above the most-significant non-zero nibble is encoded as seg=1111111 (blank). Digit 0 is never blanked, so value 0 shows "0". Dot bits are unaffected. Shadow comparison uses the blanked byte.
- Undefined: all four digits are always encoded, leading zeros shown as 1000000.

Test Plan:
- Reset then value=16'h3A0F, dots=4'b1000, WRITE_GAP=0 → writes at T+1..T+4:
  - (0, 0x0E)
  - (1, 0x40)
  - (2, 0x08)
  - (3, 0xB0)
  - ready=1 at T+5.
- Repeat the same request with SKIP_UNCHANGED=1 → no en_w pulses; ready=1 at T+5. Then value=16'h3A1F → a single write (1, 0x79) at T+2.
- WRITE_GAP=2, SKIP_UNCHANGED=0, value=16'h0000 → en_w pulses at T+1, T+4, T+7, T+10 (all data 0x40); ready=1 at T+13. valid pulses during the transaction are ignored.
- Assert rst during the 2nd write → outputs 0 immediately, no further writes. The next request for the same value rewrites all 4 digits (shadow invalidated).
- SEG7_LEADING_ZERO_BLANK_EN defined, value=16'h0050 → data: addr0=0x40, addr1=0x12, addr2=0x7F, addr3=0x7F. value=16'h0000 → addr0=0x40, addrs 1-3=0x7F.
- valid held high, values 16'h1111 then 16'h2222 → the second transaction is accepted on the first ready cycle, and its first write appears on the following cycle.
